icache_intc_req_slice: RTL and testbench

//  Registered request slice between the root of the icache_intc request arbitration tree and one

---
 rtl/icache_intc_req_slice_if.sv | 25 ++
 rtl/icache_intc_req_slice.sv | 108 ++++++++++
 tb/tb_icache_intc_req_slice.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/icache_intc_req_slice_if.sv
// Request handshake bundle used on both sides of the icache_intc request slice.
// master drives request/address/uid and receives grant; slave is the mirror view.
interface icache_intc_req_slice_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned UID_WIDTH     = 16
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [UID_WIDTH-1:0]     uid;
    logic                     grant;

    modport master (
        output request,
        output address,
        output uid,
        input  grant
    );

    modport slave (
        input  request,
        input  address,
        input  uid,
        output grant
    );
endinterface

// File: rtl/icache_intc_req_slice.sv
// Registered 2-entry skid slice between the icache_intc request tree root and a bank port,
// plus round-robin flags for the tree. Optional perf counters: ICACHE_INTC_REQ_SLICE_PERF_EN.
module icache_intc_req_slice #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned UID_WIDTH     = 16,
    parameter int unsigned N_MASTER      = 16,
    localparam int unsigned LOG_N_MASTER = $clog2(N_MASTER)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    icache_intc_req_slice_if.slave  req_in,
    icache_intc_req_slice_if.master req_out,
    output logic [LOG_N_MASTER-1:0] rr_flag_o
`ifdef ICACHE_INTC_REQ_SLICE_PERF_EN
    ,
    input  logic                    perf_clear_i,
    output logic [31:0]             perf_stall_o,
    output logic [31:0]             perf_req_o
`endif
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]              count_q, count_d;
    logic                    wr_ptr_q, rd_ptr_q;
    logic [LOG_N_MASTER-1:0] rr_flag_q;
    logic [ADDRESS_WIDTH-1:0] addr_mem_q [2];
    logic [UID_WIDTH-1:0]     uid_mem_q  [2];
    logic                    push, pop;

    // Both handshake outputs come straight from the occupancy register.
    assign req_in.grant    = (count_q != StFull);
    assign req_out.request = (count_q != StEmpty);
    assign req_out.address = addr_mem_q[rd_ptr_q];
    assign req_out.uid     = uid_mem_q[rd_ptr_q];
    assign rr_flag_o       = rr_flag_q;

    assign push = req_in.request & req_in.grant;
    assign pop  = req_out.request & req_out.grant;

    always_comb begin
        count_d = count_q;
        case (count_q)
            StEmpty: if (push) count_d = StOne;
            StOne: begin
                if (push && !pop)      count_d = StFull;
                else if (pop && !push) count_d = StEmpty;
            end
            StFull:  if (pop) count_d = StOne;
            default: count_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= StEmpty;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            rr_flag_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            // N_MASTER is a power of two, so natural overflow gives the mod-N wrap.
            if (push) rr_flag_q <= rr_flag_q + LOG_N_MASTER'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= req_in.address;
            uid_mem_q[wr_ptr_q]  <= req_in.uid;
        end
    end

`ifdef ICACHE_INTC_REQ_SLICE_PERF_EN
    logic [31:0] perf_stall_q, perf_req_q;

    assign perf_stall_o = perf_stall_q;
    assign perf_req_o   = perf_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_req_q   <= '0;
        end else if (perf_clear_i) begin
            perf_stall_q <= '0;
            perf_req_q   <= '0;
        end else begin
            if (req_out.request && !req_out.grant && perf_stall_q != 32'hFFFF_FFFF)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (pop && perf_req_q != 32'hFFFF_FFFF)
                perf_req_q <= perf_req_q + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= StFull);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == StFull));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count_q == StEmpty));
`endif

endmodule

// File: tb/tb_icache_intc_req_slice.sv
// Self-checking bench for icache_intc_req_slice: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_icache_intc_req_slice;
    localparam int AW = 32;
    localparam int UW = 16;
    localparam int NM = 8;
    localparam int LW = $clog2(NM);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] rr_flag;
    logic          perf_clear;
    logic [31:0]   perf_stall, perf_req;

    always #5 clk = ~clk;

    icache_intc_req_slice_if #(.ADDRESS_WIDTH(AW), .UID_WIDTH(UW)) up_if ();
    icache_intc_req_slice_if #(.ADDRESS_WIDTH(AW), .UID_WIDTH(UW)) dn_if ();

    icache_intc_req_slice #(
        .ADDRESS_WIDTH(AW),
        .UID_WIDTH    (UW),
        .N_MASTER     (NM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (up_if),
        .req_out     (dn_if),
        .rr_flag_o   (rr_flag)
`ifdef ICACHE_INTC_REQ_SLICE_PERF_EN
        ,
        .perf_clear_i(perf_clear),
        .perf_stall_o(perf_stall),
        .perf_req_o  (perf_req)
`endif
    );

`ifndef ICACHE_INTC_REQ_SLICE_PERF_EN
    assign perf_stall = '0;
    assign perf_req   = '0;
`endif

    // Reference model: the slice is a FIFO of capacity 2 plus a push counter mod NM.
    logic [AW+UW-1:0] mq[$];
    int unsigned      rr_m;
    logic [31:0]      stall_m, req_m;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [AW+UW-1:0] head();
        return mq[0];
    endfunction

    task automatic step(input logic req, input logic [AW-1:0] a, input logic [UW-1:0] u,
                        input logic gnt, input logic clr, output logic acc);
        logic push, pop;
        logic [AW+UW-1:0] h;
        @(negedge clk);
        check_eq("grant_o", 64'(up_if.grant), 64'(mq.size() < 2));
        check_eq("request_o", 64'(dn_if.request), 64'(mq.size() > 0));
        check_eq("rr_flag_o", 64'(rr_flag), 64'(rr_m));
        if (mq.size() > 0) begin
            h = head();
            check_eq("address_o", 64'(dn_if.address), 64'(h[AW+UW-1:UW]));
            check_eq("uid_o", 64'(dn_if.uid), 64'(h[UW-1:0]));
        end
`ifdef ICACHE_INTC_REQ_SLICE_PERF_EN
        check_eq("perf_stall_o", 64'(perf_stall), 64'(stall_m));
        check_eq("perf_req_o", 64'(perf_req), 64'(req_m));
`endif
        up_if.request = req;
        up_if.address = a;
        up_if.uid     = u;
        dn_if.grant   = gnt;
        perf_clear    = clr;
        push = req && (mq.size() < 2);
        pop  = (mq.size() > 0) && gnt;
        acc  = push;
        @(posedge clk);
        if (clr) begin
            stall_m = 0;
            req_m   = 0;
        end else begin
            if (mq.size() > 0 && !gnt) stall_m++;
            if (pop) req_m++;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back({a, u});
            rr_m = (rr_m + 1) % NM;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr_m    = 0;
        stall_m = 0;
        req_m   = 0;
    endtask

    initial begin
        logic          acc, hold;
        logic [AW-1:0] ha;
        logic [UW-1:0] hu;

        up_if.request = 1'b0;
        up_if.address = '0;
        up_if.uid     = '0;
        dn_if.grant   = 1'b0;
        perf_clear    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single request, 1-cycle latency.
        step(1'b1, 32'h100, 16'h0001, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);

        // Back-to-back stream; rr_flag wraps after NM pushes.
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'(i * 4), 16'(1 << i), 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);

        // Backpressure: fill, hold a third request, then drain in order.
        step(1'b1, 32'hA, 16'h0002, 1'b0, 1'b0, acc);
        step(1'b1, 32'hB, 16'h0004, 1'b0, 1'b0, acc);
        step(1'b1, 32'hC, 16'h0008, 1'b0, 1'b0, acc);
        step(1'b1, 32'hC, 16'h0008, 1'b1, 1'b0, acc);
        step(1'b1, 32'hC, 16'h0008, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);

        // Reset while FULL: request_o must drop without waiting for a clock edge.
        step(1'b1, 32'h200, 16'h0010, 1'b0, 1'b0, acc);
        step(1'b1, 32'h204, 16'h0020, 1'b0, 1'b0, acc);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("request_o_async_rst", 64'(dn_if.request), 64'd0);
        up_if.request = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);

`ifdef ICACHE_INTC_REQ_SLICE_PERF_EN
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b1, acc);
        step(1'b1, 32'h300, 16'h0040, 1'b0, 1'b0, acc);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, acc);
        #1 check_eq("perf_stall_5", 64'(perf_stall), 64'd5);
        step(1'b1, 32'h304, 16'h0080, 1'b1, 1'b0, acc);
        step(1'b1, 32'h308, 16'h0100, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);
        #1 check_eq("perf_req_3", 64'(perf_req), 64'd3);
        step(1'b0, 32'h0, 16'h0, 1'b0, 1'b1, acc);
        #1 check_eq("perf_clear_stall", 64'(perf_stall), 64'd0);
        check_eq("perf_clear_req", 64'(perf_req), 64'd0);
`endif

        // Random traffic; an unaccepted request is held stable until granted.
        hold = 1'b0;
        ha   = '0;
        hu   = '0;
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = hold ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (!hold) begin
                ha = $urandom();
                hu = 16'(1 << $urandom_range(0, UW - 1));
            end
            step(r, ha, hu, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, acc);
            hold = r && !acc;
        end
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
